// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM external bus arbiter.
package mem_bus_arbiter_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 255;
   localparam int CNT_W_DEF   = 8;

   localparam logic                  RST_ENABLE = 1'b1;
   localparam logic [DATA_W_DEF-1:0] ZERO_WORD  = '0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_IF_ACC  = 2'd1,
      ST_MEM_ACC = 2'd2,
      ST_DRAIN   = 2'd3
   } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester (IF, MEM) and external bus signals seen by the arbiter.
interface mem_bus_arbiter_if
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   localparam int SEL_W = DATA_W / 8;

   logic              flush;
   logic              if_ce;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_inst;
   logic              stallreq_if;
   logic              mem_ce;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [SEL_W-1:0]  mem_sel;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              stallreq_mem;
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [SEL_W-1:0]  bus_sel;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_ack;
   logic              bus_err;

   modport master (
      input  flush,
      input  if_ce, if_addr,
      output if_inst, stallreq_if,
      input  mem_ce, mem_we, mem_addr, mem_sel, mem_wdata,
      output mem_rdata, stallreq_mem,
      output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
      input  bus_rdata, bus_ack,
      output bus_err
   );

   modport slave (
      output flush,
      output if_ce, if_addr,
      input  if_inst, stallreq_if,
      output mem_ce, mem_we, mem_addr, mem_sel, mem_wdata,
      input  mem_rdata, stallreq_mem,
      input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
      output bus_rdata, bus_ack,
      input  bus_err
   );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one req/ack memory bus between instruction fetch and the MEM-stage
// load/store path; stalls each requester until its access completes.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | bus free; arbitrate, MEM before IF
// ST_IF_ACC  | fetch on the bus, waiting for ack or timeout
// ST_MEM_ACC | load/store on the bus, waiting for ack or timeout
// ST_DRAIN   | flushed access still on the bus; result is discarded
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input logic               clk,
   input logic               rst,
   mem_bus_arbiter_if.master arb_io
);

   localparam int               SEL_W    = DATA_W / 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic              bus_err_q, bus_err_d;

   logic active;
   logic timeout_hit;
   logic done_if;
   logic done_mem;

   always_comb begin
      active      = (state_q != ST_IDLE);
      timeout_hit = (TIMEOUT != 0) && active && (cnt_q == CNT_LAST) && !arb_io.bus_ack;
      done_if     = (state_q == ST_IF_ACC)  && (arb_io.bus_ack || timeout_hit);
      done_mem    = (state_q == ST_MEM_ACC) && (arb_io.bus_ack || timeout_hit);
   end

   // Timeout completes the access with zero data; the error shows up next cycle.
   assign arb_io.if_inst      = (done_if && arb_io.bus_ack)  ? arb_io.bus_rdata : DATA_W'(ZERO_WORD);
   assign arb_io.mem_rdata    = (done_mem && arb_io.bus_ack) ? arb_io.bus_rdata : DATA_W'(ZERO_WORD);
   assign arb_io.stallreq_if  = !rst && arb_io.if_ce  && !done_if;
   assign arb_io.stallreq_mem = !rst && arb_io.mem_ce && !done_mem;

   assign arb_io.bus_req   = bus_req_q;
   assign arb_io.bus_we    = bus_we_q;
   assign arb_io.bus_addr  = bus_addr_q;
   assign arb_io.bus_sel   = bus_sel_q;
   assign arb_io.bus_wdata = bus_wdata_q;
   assign arb_io.bus_err   = bus_err_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_sel_d   = bus_sel_q;
      bus_wdata_d = bus_wdata_q;
      bus_err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // MEM holds the older instruction, so it wins a tie.
            if (arb_io.mem_ce) begin
               state_d     = ST_MEM_ACC;
               cnt_d       = '0;
               bus_req_d   = 1'b1;
               bus_we_d    = arb_io.mem_we;
               bus_addr_d  = arb_io.mem_addr;
               bus_sel_d   = arb_io.mem_sel;
               bus_wdata_d = arb_io.mem_wdata;
            end else if (arb_io.if_ce) begin
               state_d     = ST_IF_ACC;
               cnt_d       = '0;
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b0;
               bus_addr_d  = arb_io.if_addr;
               bus_sel_d   = '1;
               bus_wdata_d = '0;
            end
         end

         ST_IF_ACC, ST_MEM_ACC: begin
            cnt_d = cnt_q + 1'b1;
            if (arb_io.bus_ack || timeout_hit) begin
               state_d   = ST_IDLE;
               bus_req_d = 1'b0;
               bus_err_d = timeout_hit;
            end else if (arb_io.flush) begin
               state_d = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            cnt_d = cnt_q + 1'b1;
            if (arb_io.bus_ack || timeout_hit) begin
               state_d   = ST_IDLE;
               bus_req_d = 1'b0;
               bus_err_d = timeout_hit;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_sel_q   <= '0;
         bus_wdata_q <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_sel_q   <= bus_sel_d;
         bus_wdata_q <= bus_wdata_d;
         bus_err_q   <= bus_err_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized scoreboard bench for mem_bus_arbiter: a bus slave model with
// per-access ack latency, and expected completions computed per round.
module tb_mem_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int T  = 4;
   localparam int CW = 8;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [SW-1:0] sel;
      logic [DW-1:0] wdata;
      int            dur;
   } bus_exp_t;

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } done_exp_t;

   typedef struct {
      int            lat;
      logic [DW-1:0] rdata;
   } resp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   total;
   int   bad;
   bit   resp_en;
   bit   rst_evt;

   bus_exp_t  bus_q[$];
   done_exp_t if_q[$];
   done_exp_t mem_q[$];
   resp_t     resp_q[$];
   int        err_q[$];

   mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

   mem_bus_arbiter #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .TIMEOUT(T),
      .CNT_W  (CW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .arb_io(ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial rst_evt = 1'b0;
   always @(posedge rst) rst_evt = 1'b1;

   task automatic chk_v(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [127:0] pk(input logic we, input logic [AW-1:0] a,
                                       input logic [SW-1:0] s, input logic [DW-1:0] w);
      return {59'b0, we, a, s, w};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bus slave: acks in the lat-th cycle of bus_req, or never if lat >= T.
   initial begin : responder
      bit    in_txn;
      int    k;
      resp_t r;
      in_txn = 1'b0;
      k = 0;
      r = '{1000, '0};
      ifc.bus_ack = 1'b0;
      ifc.bus_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         ifc.bus_ack = 1'b0;
         ifc.bus_rdata = $urandom();
         if (resp_en && !rst && ifc.bus_req) begin
            if (!in_txn) begin
               if (resp_q.size() == 0) begin
                  chk_i("resp_underflow", 1, 0);
                  r = '{1000, '0};
               end else begin
                  r = resp_q.pop_front();
               end
               in_txn = 1'b1;
               k = 0;
            end else begin
               k++;
            end
            if (k == r.lat) begin
               ifc.bus_ack = 1'b1;
               ifc.bus_rdata = r.rdata;
            end
         end else begin
            in_txn = 1'b0;
         end
      end
   end

   initial begin : bus_mon
      bit             prev_req;
      int             dur;
      bus_exp_t       e;
      logic [127:0]   cur;
      prev_req = 1'b0;
      dur = 0;
      e = '{1'b0, '0, '0, '0, 0};
      cur = '0;
      forever begin
         @(negedge clk);
         if (rst || rst_evt) begin
            prev_req = 1'b0;
            dur = 0;
            rst_evt = 1'b0;
         end else begin
            if (ifc.bus_req && !prev_req) begin
               cur = pk(ifc.bus_we, ifc.bus_addr, ifc.bus_sel, ifc.bus_wdata);
               dur = 1;
               if (bus_q.size() == 0) begin
                  chk_i("bus_unexpected_req", 1, 0);
               end else begin
                  e = bus_q.pop_front();
                  chk_v("bus_fields", cur, pk(e.we, e.addr, e.sel, e.wdata));
               end
            end else if (ifc.bus_req) begin
               dur++;
               chk_v("bus_stable", pk(ifc.bus_we, ifc.bus_addr, ifc.bus_sel, ifc.bus_wdata), cur);
            end else if (prev_req) begin
               chk_i("bus_req_len", dur, e.dur);
            end
            prev_req = ifc.bus_req;
         end
         if (ifc.bus_err) begin
            if (err_q.size() == 0) chk_i("bus_err_unexpected", 1, 0);
            else chk_i("bus_err_cycle", cyc, err_q.pop_front());
         end else if (err_q.size() > 0 && err_q[0] < cyc) begin
            chk_i("bus_err_missing", 0, err_q.pop_front());
         end
      end
   end

   initial begin : done_mon
      done_exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (ifc.if_ce && !ifc.stallreq_if) begin
               if (if_q.size() == 0) begin
                  chk_i("if_unexpected_done", 1, 0);
               end else begin
                  e = if_q.pop_front();
                  chk_v("if_inst", 128'(ifc.if_inst), 128'(e.data));
                  chk_i("if_done_cycle", cyc, e.cyc);
               end
            end else begin
               chk_v("if_inst_zero", 128'(ifc.if_inst), 128'(0));
            end
            if (ifc.mem_ce && !ifc.stallreq_mem) begin
               if (mem_q.size() == 0) begin
                  chk_i("mem_unexpected_done", 1, 0);
               end else begin
                  e = mem_q.pop_front();
                  chk_v("mem_rdata", 128'(ifc.mem_rdata), 128'(e.data));
                  chk_i("mem_done_cycle", cyc, e.cyc);
               end
            end else begin
               chk_v("mem_rdata_zero", 128'(ifc.mem_rdata), 128'(0));
            end
         end
      end
   end

   // One round starts with the arbiter idle; expected bus traffic, completion
   // cycles and error pulses follow from the ack latencies chosen here.
   task automatic do_round(input bit use_mem, input bit use_if, input bit we,
                           input logic [AW-1:0] maddr, input logic [SW-1:0] msel,
                           input logic [DW-1:0] mwd, input int lm, input logic [DW-1:0] rdm,
                           input logic [AW-1:0] iaddr, input int li, input logic [DW-1:0] rdi,
                           input int flush_at);
      int s, dm, di, dl, base;
      bit mfin, ifin;
      s = cyc;
      dm = s;
      if (use_mem) begin
         dl = (lm < T) ? lm : T - 1;
         dm = s + 1 + dl;
         bus_q.push_back(bus_exp_t'{we, maddr, msel, mwd, dl + 1});
         resp_q.push_back(resp_t'{lm, rdm});
         if (flush_at < 0) mem_q.push_back(done_exp_t'{(lm < T) ? rdm : '0, dm});
         if (lm >= T) err_q.push_back(dm + 1);
         ifc.mem_ce = 1'b1;
         ifc.mem_we = we;
         ifc.mem_addr = maddr;
         ifc.mem_sel = msel;
         ifc.mem_wdata = mwd;
      end
      if (use_if) begin
         base = use_mem ? dm + 1 : s;
         dl = (li < T) ? li : T - 1;
         di = base + 1 + dl;
         bus_q.push_back(bus_exp_t'{1'b0, iaddr, {SW{1'b1}}, '0, dl + 1});
         resp_q.push_back(resp_t'{li, rdi});
         if (flush_at < 0) if_q.push_back(done_exp_t'{(li < T) ? rdi : '0, di});
         if (li >= T) err_q.push_back(di + 1);
         ifc.if_ce = 1'b1;
         ifc.if_addr = iaddr;
      end
      for (int k = 0; k < 64 && (ifc.mem_ce || ifc.if_ce); k++) begin
         @(negedge clk);
         mfin = ifc.mem_ce && !ifc.stallreq_mem;
         ifin = ifc.if_ce && !ifc.stallreq_if;
         tick();
         ifc.flush = 1'b0;
         if (mfin) ifc.mem_ce = 1'b0;
         if (ifin) ifc.if_ce = 1'b0;
         if (flush_at >= 0 && cyc == s + 1 + flush_at) begin
            ifc.flush = 1'b1;
            ifc.mem_ce = 1'b0;
            ifc.if_ce = 1'b0;
         end
      end
      if (ifc.mem_ce || ifc.if_ce) begin
         chk_i("round_budget_expired", 1, 0);
         ifc.mem_ce = 1'b0;
         ifc.if_ce = 1'b0;
      end
      if (ifc.flush) begin
         tick();
         ifc.flush = 1'b0;
      end
      for (int k = 0; k < 32 && ifc.bus_req; k++) tick();
      if (ifc.bus_req) chk_i("drain_budget_expired", 1, 0);
   endtask

   task automatic reset_test();
      resp_en = 1'b0;
      bus_q.push_back(bus_exp_t'{1'b0, 32'h0000_0300, 4'hF, '0, 0});
      ifc.mem_ce = 1'b1;
      ifc.mem_we = 1'b0;
      ifc.mem_addr = 32'h0000_0300;
      ifc.mem_sel = 4'hF;
      ifc.mem_wdata = '0;
      tick();
      tick();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_i("rst_mid_bus_req", int'(ifc.bus_req), 0);
      chk_i("rst_mid_stallreq_mem", int'(ifc.stallreq_mem), 0);
      chk_v("rst_mid_bus_fields", pk(ifc.bus_we, ifc.bus_addr, ifc.bus_sel, ifc.bus_wdata), 128'(0));
      rst = 1'b0;
      ifc.mem_ce = 1'b0;
      @(posedge clk);
      #2;
      ifc.bus_ack = 1'b1;
      ifc.bus_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk_i("late_ack_bus_req", int'(ifc.bus_req), 0);
      @(posedge clk);
      #2;
      ifc.bus_ack = 1'b0;
      @(negedge clk);
      chk_i("late_ack_no_start", int'(ifc.bus_req), 0);
      chk_i("late_ack_no_err", int'(ifc.bus_err), 0);
      resp_en = 1'b1;
      tick();
   endtask

   initial begin : stim
      int um, ui, lm, li, fl, lsel, hi;
      total = 0;
      bad = 0;
      resp_en = 1'b1;
      rst = 1'b1;
      ifc.flush = 1'b0;
      ifc.if_ce = 1'b1;
      ifc.if_addr = 32'h0000_0040;
      ifc.mem_ce = 1'b1;
      ifc.mem_we = 1'b1;
      ifc.mem_addr = 32'h0000_0080;
      ifc.mem_sel = 4'hF;
      ifc.mem_wdata = 32'h1234_5678;
      repeat (3) @(posedge clk);
      #1;
      chk_i("reset_bus_req", int'(ifc.bus_req), 0);
      chk_i("reset_bus_err", int'(ifc.bus_err), 0);
      chk_v("reset_bus_fields", pk(ifc.bus_we, ifc.bus_addr, ifc.bus_sel, ifc.bus_wdata), 128'(0));
      chk_i("reset_stallreq_if", int'(ifc.stallreq_if), 0);
      chk_i("reset_stallreq_mem", int'(ifc.stallreq_mem), 0);
      ifc.if_ce = 1'b0;
      ifc.mem_ce = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      tick();

      do_round(0, 1, 0, '0, '0, '0, 0, '0, 32'h0000_0100, 1, 32'h3C01_1234, -1);
      do_round(1, 1, 1, 32'h0000_0200, 4'b0011, 32'hA5A5_0F0F, 1, 32'h1111_2222,
               32'h0000_0104, 0, 32'h3333_4444, -1);
      do_round(1, 0, 0, 32'h0000_0300, 4'hF, '0, 3, 32'h5555_6666, '0, 0, '0, 1);
      do_round(1, 0, 0, 32'h0000_0400, 4'hF, '0, 9, 32'h7777_8888, '0, 0, '0, -1);
      do_round(0, 1, 0, '0, '0, '0, 0, '0, 32'h0000_0500, 9, 32'h9999_AAAA, -1);
      reset_test();
      do_round(1, 0, 0, 32'h0000_0000, 4'hF, '0, 0, 32'h0BAD_0000, '0, 0, '0, -1);
      do_round(1, 0, 0, 32'h0000_0004, 4'hF, '0, 0, 32'h0BAD_0004, '0, 0, '0, -1);

      repeat (150) begin
         repeat ($urandom_range(0, 2)) tick();
         um = int'($urandom_range(0, 1));
         ui = int'($urandom_range(0, 1));
         if (um == 0 && ui == 0) ui = 1;
         lm = int'($urandom_range(0, 5));
         li = int'($urandom_range(0, 5));
         fl = -1;
         if (um != ui && $urandom_range(0, 4) == 0) begin
            lsel = (um != 0) ? lm : li;
            if (lsel > 0) begin
               hi = ((lsel < T) ? lsel : T) - 1;
               fl = int'($urandom_range(0, hi));
            end
         end
         do_round(um != 0, ui != 0, 1'($urandom_range(0, 1)), $urandom(),
                  4'($urandom_range(0, 15)), $urandom(), lm, $urandom(),
                  $urandom(), li, $urandom(), fl);
      end

      repeat (4) tick();
      chk_i("leftover_bus_q", bus_q.size(), 0);
      chk_i("leftover_resp_q", resp_q.size(), 0);
      chk_i("leftover_if_q", if_q.size(), 0);
      chk_i("leftover_mem_q", mem_q.size(), 0);
      chk_i("leftover_err_q", err_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
